// File: rtl/usbfs_in_packetizer_pkg.sv
// Shared constants and state encoding for the full-speed IN endpoint packetizer.
// PID values are the 4-bit USB PID codes handed to the packet transmitter.
package usbfs_in_packetizer_pkg;
   localparam logic [3:0] PID_DATA_DATA0    = 4'b0011;
   localparam logic [3:0] PID_DATA_DATA1    = 4'b1011;
   localparam logic [3:0] PID_HANDSHAKE_NAK = 4'b1010;

   typedef enum logic [2:0] {
      ST_FILL,
      ST_SEND,
      ST_WAIT_EOP,
      ST_WAIT_ACK,
      ST_HOLD
   } state_t;

   function automatic logic [3:0] data_pid(input logic toggle);
      return toggle ? PID_DATA_DATA1 : PID_DATA_DATA0;
   endfunction
endpackage

// File: rtl/usbfs_in_packetizer_buf.sv
// Byte-write payload buffer with fill count; bytes land at index count.
// Shared shape for IN and OUT endpoints: the caller owns when to write and clear.
module usbfs_in_packetizer_buf
   import usbfs_in_packetizer_pkg::*;
#(
   parameter int MAX_PKT = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_wr,
   input  logic                       i_clr,
   input  logic [7:0]                 i_byte,
   output logic [8*MAX_PKT-1:0]       o_data,
   output logic [$clog2(MAX_PKT):0]   o_count
);
   localparam int CW = $clog2(MAX_PKT) + 1;

   logic [MAX_PKT-1:0][7:0] r_mem;
   logic [CW-1:0]           r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   r_count <= '0;
      else if (i_clr) r_count <= '0;
      else if (i_wr)  r_count <= r_count + 1'b1;
   end

   // Payload storage carries no reset; contents are only meaningful below count.
   always_ff @(posedge i_clk) begin
      if (i_wr && !i_clr) r_mem[r_count[CW-2:0]] <= i_byte;
   end

   assign o_data  = r_mem;
   assign o_count = r_count;

   a_count_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      r_count <= CW'(MAX_PKT));
endmodule

// File: rtl/usbfs_in_packetizer.sv
// IN endpoint packetizer: fills a payload, answers IN with DATAx/NAK, retains it until ACK.
// Define USBFS_IN_PACKETIZER_STATS_EN to build the NAK/retry counters.
module usbfs_in_packetizer
   import usbfs_in_packetizer_pkg::*;
#(
   parameter int MAX_PKT = 8
) (
   input  logic                       i_clk_12MHz,
   input  logic                       i_rst_n,
   input  logic                       i_byte_valid,
   output logic                       o_byte_ready,
   input  logic [7:0]                 i_byte,
   input  logic                       i_flush,
   input  logic                       i_inToken,
   input  logic                       i_ack,
   input  logic                       i_ackTimeout,
   input  logic                       i_toggleClr,
   output logic                       o_txValid,
   input  logic                       i_txReady,
   output logic [3:0]                 o_txPid,
   output logic [8*MAX_PKT-1:0]       o_txData,
   output logic [$clog2(MAX_PKT):0]   o_txData_nBytes,
   input  logic                       i_txEopDone,
   output logic                       o_toggle,
   output logic [15:0]                o_nakCount,
   output logic [15:0]                o_retryCount
);
   localparam int CW = $clog2(MAX_PKT) + 1;

   state_t        r_state,  w_stateNx;
   logic          r_toggle, w_toggleNx;
   logic          r_flushPend, w_flushNx;
   logic          r_clrPend, w_clrPendNx;
   logic          r_txValid, w_validNx;
   logic [3:0]    r_txPid, w_pidNx;
   logic [CW-1:0] r_nBytes, w_nBytesNx;
   logic          r_isNak, w_isNakNx;
   logic          w_bufClr;
   logic          w_accept;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_cntNx;

   assign o_byte_ready = (r_state == ST_FILL) && (w_count < CW'(MAX_PKT)) && !r_flushPend;
   assign w_accept     = i_byte_valid && o_byte_ready;
   // A byte accepted in the token cycle still belongs to the answered payload.
   assign w_cntNx      = w_count + CW'(w_accept);

   usbfs_in_packetizer_buf #(.MAX_PKT(MAX_PKT)) u_buf (
      .i_clk   (i_clk_12MHz),
      .i_rst_n (i_rst_n),
      .i_wr    (w_accept),
      .i_clr   (w_bufClr),
      .i_byte  (i_byte),
      .o_data  (o_txData),
      .o_count (w_count)
   );

   always_ff @(posedge i_clk_12MHz or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_FILL;
         r_toggle    <= 1'b0;
         r_flushPend <= 1'b0;
         r_clrPend   <= 1'b0;
         r_txValid   <= 1'b0;
         r_txPid     <= '0;
         r_nBytes    <= '0;
         r_isNak     <= 1'b0;
      end else begin
         r_state     <= w_stateNx;
         r_toggle    <= w_toggleNx;
         r_flushPend <= w_flushNx;
         r_clrPend   <= w_clrPendNx;
         r_txValid   <= w_validNx;
         r_txPid     <= w_pidNx;
         r_nBytes    <= w_nBytesNx;
         r_isNak     <= w_isNakNx;
      end
   end

   always_comb begin
      w_stateNx   = r_state;
      w_toggleNx  = r_toggle;
      w_flushNx   = r_flushPend;
      w_clrPendNx = r_clrPend;
      w_validNx   = r_txValid;
      w_pidNx     = r_txPid;
      w_nBytesNx  = r_nBytes;
      w_isNakNx   = r_isNak;
      w_bufClr    = 1'b0;
      case (r_state)
         ST_FILL: begin
            if (i_toggleClr) begin
               w_toggleNx = 1'b0;
               w_flushNx  = 1'b0;
               w_bufClr   = 1'b1;
            end else begin
               if (i_flush) w_flushNx = 1'b1;
               if (i_inToken) begin
                  w_stateNx = ST_SEND;
                  w_validNx = 1'b1;
                  if (w_cntNx == CW'(MAX_PKT) || r_flushPend || i_flush) begin
                     w_pidNx    = data_pid(r_toggle);
                     w_nBytesNx = w_cntNx;
                     w_isNakNx  = 1'b0;
                  end else begin
                     w_pidNx    = PID_HANDSHAKE_NAK;
                     w_nBytesNx = '0;
                     w_isNakNx  = 1'b1;
                  end
               end
            end
         end
         ST_SEND: begin
            if (i_toggleClr) w_clrPendNx = 1'b1;
            if (r_txValid && i_txReady) begin
               w_validNx = 1'b0;
               w_stateNx = ST_WAIT_EOP;
            end
         end
         ST_WAIT_EOP: begin
            if (i_txEopDone) begin
               // A clear that arrived mid-packet takes effect once the packet is on the wire.
               if (r_clrPend || i_toggleClr) begin
                  w_stateNx   = ST_FILL;
                  w_toggleNx  = 1'b0;
                  w_flushNx   = 1'b0;
                  w_clrPendNx = 1'b0;
                  w_bufClr    = 1'b1;
               end else begin
                  w_stateNx = r_isNak ? ST_FILL : ST_WAIT_ACK;
               end
            end else if (i_toggleClr) begin
               w_clrPendNx = 1'b1;
            end
         end
         ST_WAIT_ACK: begin
            if (i_toggleClr) begin
               w_stateNx  = ST_FILL;
               w_toggleNx = 1'b0;
               w_flushNx  = 1'b0;
               w_bufClr   = 1'b1;
            end else if (i_ack) begin
               w_stateNx  = ST_FILL;
               w_toggleNx = !r_toggle;
               w_flushNx  = 1'b0;
               w_bufClr   = 1'b1;
            end else if (i_ackTimeout) begin
               w_stateNx = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (i_toggleClr) begin
               w_stateNx  = ST_FILL;
               w_toggleNx = 1'b0;
               w_flushNx  = 1'b0;
               w_bufClr   = 1'b1;
            end else if (i_inToken) begin
               w_stateNx = ST_SEND;
               w_validNx = 1'b1;
            end
         end
         default: w_stateNx = ST_FILL;
      endcase
   end

   assign o_txValid       = r_txValid;
   assign o_txPid         = r_txPid;
   assign o_txData_nBytes = r_nBytes;
   assign o_toggle        = r_toggle;

`ifdef USBFS_IN_PACKETIZER_STATS_EN
   logic [15:0] r_nakCount;
   logic [15:0] r_retryCount;
   logic        w_nakSent;
   logic        w_retry;

   assign w_nakSent = r_txValid && i_txReady && r_isNak;
   assign w_retry   = (r_state == ST_HOLD) && i_inToken && !i_toggleClr;

   always_ff @(posedge i_clk_12MHz or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_nakCount   <= '0;
         r_retryCount <= '0;
      end else begin
         if (w_nakSent && r_nakCount != 16'hFFFF)   r_nakCount   <= r_nakCount + 16'd1;
         if (w_retry && r_retryCount != 16'hFFFF)   r_retryCount <= r_retryCount + 16'd1;
      end
   end

   assign o_nakCount   = r_nakCount;
   assign o_retryCount = r_retryCount;
`else
   assign o_nakCount   = 16'd0;
   assign o_retryCount = 16'd0;
`endif
endmodule

// File: tb/tb_usbfs_in_packetizer.sv
// Directed bench for usbfs_in_packetizer (MAX_PKT=8): fill/NAK/ZLP/retry/clear/reset scenarios.
module tb_usbfs_in_packetizer;
   logic        clk;
   logic        rst_n;
   logic        byte_valid, byte_ready;
   logic [7:0]  byte_in;
   logic        flush, in_tok, ack, ack_to, tog_clr;
   logic        tx_valid, tx_ready, eop_done;
   logic [3:0]  tx_pid;
   logic [63:0] tx_data;
   logic [3:0]  tx_nbytes;
   logic        toggle;
   logic [15:0] nak_cnt, retry_cnt;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [3:0] P_D0  = 4'h3;
   localparam logic [3:0] P_D1  = 4'hB;
   localparam logic [3:0] P_NAK = 4'hA;

   usbfs_in_packetizer #(.MAX_PKT(8)) dut (
      .i_clk_12MHz     (clk),
      .i_rst_n         (rst_n),
      .i_byte_valid    (byte_valid),
      .o_byte_ready    (byte_ready),
      .i_byte          (byte_in),
      .i_flush         (flush),
      .i_inToken       (in_tok),
      .i_ack           (ack),
      .i_ackTimeout    (ack_to),
      .i_toggleClr     (tog_clr),
      .o_txValid       (tx_valid),
      .i_txReady       (tx_ready),
      .o_txPid         (tx_pid),
      .o_txData        (tx_data),
      .o_txData_nBytes (tx_nbytes),
      .i_txEopDone     (eop_done),
      .o_toggle        (toggle),
      .o_nakCount      (nak_cnt),
      .o_retryCount    (retry_cnt)
   );

   initial clk = 1'b0;
   always #42 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_in    = b;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1; tick(); flush = 1'b0;
   endtask

   task automatic do_in(input string tag);
      int n;
      in_tok = 1'b1; tick(); in_tok = 1'b0;
      n = 0;
      while (!tx_valid && n < 20) begin tick(); n++; end
      chk({tag, "_valid"}, {63'd0, tx_valid}, 64'd1);
   endtask

   task automatic do_send(input string tag);
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
      chk({tag, "_vdrop"}, {63'd0, tx_valid}, 64'd0);
   endtask

   task automatic do_eop();
      eop_done = 1'b1; tick(); eop_done = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; flush = 1'b0; in_tok = 1'b0;
      ack = 1'b0; ack_to = 1'b0; tog_clr = 1'b0; tx_ready = 1'b0; eop_done = 1'b0;
      #100 rst_n = 1'b1;
      tick();

      chk("rst_ready",  {63'd0, byte_ready}, 64'd1);
      chk("rst_valid",  {63'd0, tx_valid},   64'd0);
      chk("rst_pid",    {60'd0, tx_pid},     64'd0);
      chk("rst_nbytes", {60'd0, tx_nbytes},  64'd0);
      chk("rst_toggle", {63'd0, toggle},     64'd0);
      chk("rst_nak",    {48'd0, nak_cnt},    64'd0);
      chk("rst_retry",  {48'd0, retry_cnt},  64'd0);

      // T1: full packet
      for (int i = 1; i <= 8; i++) push(8'(i));
      chk("t1_full_ready", {63'd0, byte_ready}, 64'd0);
      do_in("t1");
      chk("t1_pid",    {60'd0, tx_pid},    {60'd0, P_D0});
      chk("t1_nbytes", {60'd0, tx_nbytes}, 64'd8);
      chk("t1_data",   tx_data,            64'h0807060504030201);
      tick(); tick();
      chk("t1_hold_valid", {63'd0, tx_valid}, 64'd1);
      chk("t1_hold_pid",   {60'd0, tx_pid},   {60'd0, P_D0});
      do_send("t1");
      do_eop();
      do_ack();
      chk("t1_toggle", {63'd0, toggle},     64'd1);
      chk("t1_ready",  {63'd0, byte_ready}, 64'd1);

      // T2: partial without flush -> NAK, then flush -> DATA1
      push(8'hAA); push(8'hBB); push(8'hCC);
      do_in("t2n");
      chk("t2_nak_pid", {60'd0, tx_pid}, {60'd0, P_NAK});
      do_send("t2n");
      do_eop();
      chk("t2_nak_fill", {63'd0, byte_ready}, 64'd1);
      chk("t2_nak_tog",  {63'd0, toggle},     64'd1);
      do_flush();
      chk("t2_flush_ready", {63'd0, byte_ready}, 64'd0);
      do_in("t2d");
      chk("t2_pid",    {60'd0, tx_pid},    {60'd0, P_D1});
      chk("t2_nbytes", {60'd0, tx_nbytes}, 64'd3);
      chk("t2_data",   {40'd0, tx_data[23:0]}, 64'hCCBBAA);
      do_send("t2d");
      do_eop();
      do_ack();
      chk("t2_toggle", {63'd0, toggle}, 64'd0);

      // T3: zero-length packet
      do_flush();
      do_in("t3");
      chk("t3_pid",    {60'd0, tx_pid},    {60'd0, P_D0});
      chk("t3_nbytes", {60'd0, tx_nbytes}, 64'd0);
      do_send("t3");
      do_eop();
      do_ack();
      chk("t3_toggle", {63'd0, toggle}, 64'd1);

      // T4: clear to DATA0, timeout, retransmit
      tog_clr = 1'b1; tick(); tog_clr = 1'b0;
      chk("t4_clr_tog", {63'd0, toggle}, 64'd0);
      push(8'h11); push(8'h22);
      do_flush();
      do_in("t4a");
      chk("t4a_pid",    {60'd0, tx_pid},    {60'd0, P_D0});
      chk("t4a_nbytes", {60'd0, tx_nbytes}, 64'd2);
      do_send("t4a");
      do_eop();
      ack_to = 1'b1; tick(); ack_to = 1'b0;
      chk("t4_hold_ready", {63'd0, byte_ready}, 64'd0);
      do_in("t4b");
      chk("t4b_pid",    {60'd0, tx_pid},    {60'd0, P_D0});
      chk("t4b_nbytes", {60'd0, tx_nbytes}, 64'd2);
      chk("t4b_data",   {48'd0, tx_data[15:0]}, 64'h2211);
      do_send("t4b");
      do_eop();
      do_ack();
      chk("t4_toggle", {63'd0, toggle}, 64'd1);
`ifdef USBFS_IN_PACKETIZER_STATS_EN
      chk("t4_retry", {48'd0, retry_cnt}, 64'd1);
      chk("t4_nak",   {48'd0, nak_cnt},   64'd1);
`else
      chk("t4_retry", {48'd0, retry_cnt}, 64'd0);
      chk("t4_nak",   {48'd0, nak_cnt},   64'd0);
`endif

      // T5: toggle clear during WAIT_EOP of DATA1
      push(8'h5A);
      do_flush();
      do_in("t5");
      chk("t5_pid", {60'd0, tx_pid}, {60'd0, P_D1});
      do_send("t5");
      tog_clr = 1'b1; tick(); tog_clr = 1'b0;
      chk("t5_tog_inflight", {63'd0, toggle}, 64'd1);
      do_eop();
      chk("t5_tog_after", {63'd0, toggle},     64'd0);
      chk("t5_ready",     {63'd0, byte_ready}, 64'd1);
      do_flush();
      do_in("t5z");
      chk("t5z_pid",    {60'd0, tx_pid},    {60'd0, P_D0});
      chk("t5z_nbytes", {60'd0, tx_nbytes}, 64'd0);
      do_send("t5z");
      do_eop();
      do_ack();

      // T6: async reset while a packet is offered
      push(8'h77);
      do_flush();
      do_in("t6");
      #5 rst_n = 1'b0;
      #1;
      chk("t6_async_valid", {63'd0, tx_valid}, 64'd0);
      #10 rst_n = 1'b1;
      tick();
      chk("t6_ready",  {63'd0, byte_ready}, 64'd1);
      chk("t6_toggle", {63'd0, toggle},     64'd0);
      chk("t6_pid",    {60'd0, tx_pid},     64'd0);
      chk("t6_valid",  {63'd0, tx_valid},   64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
